// File: rtl/pss_peak_detector.sv
// pss_peak_detector
// Peak detector behind the PSS correlator.
// - Keeps a moving sum of the WINDOW_LEN samples before the current one.
// - Arms on a sample above (avg << DETECTION_SHIFT).
// - Refines the peak to the local maximum, reports it as a one-cycle pulse,
//   then ignores HOLDOFF_LEN samples before re-arming.
// Optional feature macro: PSS_PEAK_DETECTOR_CFO_CAPTURE_EN. When defined, it
// captures the correlator half sums C0/C1 together with the peak sample.
module pss_peak_detector #(
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
  parameter int C_DW            = 64,
`endif
  parameter int IN_DW           = 24,
  parameter int WINDOW_LEN      = 8,
  parameter int DETECTION_SHIFT = 2,
  parameter int PEAK_WIN        = 4,
  parameter int HOLDOFF_LEN     = 16,
  parameter int IDX_DW          = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [IN_DW-1:0]                 s_axis_in_tdata,
  input  logic                             s_axis_in_tvalid,
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
  input  logic [C_DW-1:0]                  C0_i,
  input  logic [C_DW-1:0]                  C1_i,
  output logic [C_DW-1:0]                  C0_o,
  output logic [C_DW-1:0]                  C1_o,
`endif
  output logic                             peak_detected_o,
  output logic [IDX_DW-1:0]                peak_idx_o,
  output logic [IN_DW-1:0]                 peak_val_o,
  output logic [IN_DW+DETECTION_SHIFT-1:0] score_o
);

  localparam int LOG2W    = $clog2(WINDOW_LEN);
  localparam int SUM_DW   = IN_DW + LOG2W;
  localparam int THR_DW   = IN_DW + DETECTION_SHIFT;
  localparam int WARM_DW  = $clog2(WINDOW_LEN + 1);
  localparam int QUIET_DW = $clog2(PEAK_WIN + 1);
  localparam int HOLD_DW  = $clog2(HOLDOFF_LEN + 1);

  localparam logic [IDX_DW-1:0]   IDX_ONE     = IDX_DW'(1);
  localparam logic [WARM_DW-1:0]  WARM_ONE    = WARM_DW'(1);
  localparam logic [WARM_DW-1:0]  WARM_DONE   = WARM_DW'(WINDOW_LEN);
  localparam logic [QUIET_DW-1:0] QUIET_ONE   = QUIET_DW'(1);
  localparam logic [QUIET_DW-1:0] PEAK_WIN_M1 = QUIET_DW'(PEAK_WIN - 1);
  localparam logic [HOLD_DW-1:0]  HOLD_ONE    = HOLD_DW'(1);
  localparam logic [HOLD_DW-1:0]  HOLD_M1     = HOLD_DW'(HOLDOFF_LEN - 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  logic [IN_DW-1:0]    dline_r [WINDOW_LEN];
  logic [SUM_DW-1:0]   sum_r;
  logic [IDX_DW-1:0]   sample_cnt_r;
  logic [WARM_DW-1:0]  warm_cnt_r;

  state_t              state_r, state_n;
  logic [QUIET_DW-1:0] quiet_r, quiet_n;
  logic [HOLD_DW-1:0]  hold_r, hold_n;
  logic [IN_DW-1:0]    max_r;
  logic [IDX_DW-1:0]   max_idx_r;

  logic [IN_DW-1:0]    avg_s;
  logic [THR_DW-1:0]   thr_s;
  logic                warm_done_s;
  logic                cand_s;
  logic                load_max_s;
  logic                report_s;

`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
  logic [C_DW-1:0]     c0_max_r;
  logic [C_DW-1:0]     c1_max_r;
`endif

  // The sum excludes the current sample, so the threshold depends only on history.
  assign avg_s       = sum_r[SUM_DW-1:LOG2W];
  assign thr_s       = THR_DW'(avg_s) << DETECTION_SHIFT;
  assign warm_done_s = (warm_cnt_r == WARM_DONE);
  assign cand_s      = warm_done_s && (THR_DW'(s_axis_in_tdata) > thr_s);
  assign score_o     = thr_s;

  // Delay line, running sum, sample index and warm-up counter advance on every accepted sample.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < WINDOW_LEN; i++) begin
        dline_r[i] <= '0;
      end
      sum_r        <= '0;
      sample_cnt_r <= '0;
      warm_cnt_r   <= '0;
    end else if (s_axis_in_tvalid) begin
      dline_r[0] <= s_axis_in_tdata;
      for (int i = 1; i < WINDOW_LEN; i++) begin
        dline_r[i] <= dline_r[i-1];
      end
      sum_r        <= sum_r + SUM_DW'(s_axis_in_tdata) - SUM_DW'(dline_r[WINDOW_LEN-1]);
      sample_cnt_r <= sample_cnt_r + IDX_ONE;
      if (!warm_done_s) begin
        warm_cnt_r <= warm_cnt_r + WARM_ONE;
      end
    end
  end

  // FSM state and the quiet/hold-off counters.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r <= ST_SEARCH;
      quiet_r <= '0;
      hold_r  <= '0;
    end else begin
      state_r <= state_n;
      quiet_r <= quiet_n;
      hold_r  <= hold_n;
    end
  end

  // Next-state logic; transitions happen only on accepted samples.
  always_comb begin
    state_n    = state_r;
    quiet_n    = quiet_r;
    hold_n     = hold_r;
    load_max_s = 1'b0;
    report_s   = 1'b0;
    if (s_axis_in_tvalid) begin
      case (state_r)
        ST_SEARCH: begin
          if (cand_s) begin
            state_n    = ST_TRACK;
            load_max_s = 1'b1;
            quiet_n    = '0;
          end else begin
            state_n = ST_SEARCH;
          end
        end
        ST_TRACK: begin
          // Strict compare keeps the earliest index among equal maxima.
          if (s_axis_in_tdata > max_r) begin
            load_max_s = 1'b1;
            quiet_n    = '0;
          end else if (quiet_r == PEAK_WIN_M1) begin
            report_s = 1'b1;
            state_n  = ST_HOLDOFF;
            quiet_n  = '0;
            hold_n   = '0;
          end else begin
            quiet_n = quiet_r + QUIET_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (hold_r == HOLD_M1) begin
            state_n = ST_SEARCH;
            hold_n  = '0;
          end else begin
            hold_n = hold_r + HOLD_ONE;
          end
        end
        default: begin
          state_n = ST_SEARCH;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Running maximum of the current peak and its context.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      max_r     <= '0;
      max_idx_r <= '0;
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
      c0_max_r  <= '0;
      c1_max_r  <= '0;
`endif
    end else if (load_max_s) begin
      max_r     <= s_axis_in_tdata;
      max_idx_r <= sample_cnt_r;
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
      c0_max_r  <= C0_i;
      c1_max_r  <= C1_i;
`endif
    end
  end

  // Report registers: one-cycle pulse, values held until the next report.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      peak_detected_o <= 1'b0;
      peak_idx_o      <= '0;
      peak_val_o      <= '0;
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
      C0_o            <= '0;
      C1_o            <= '0;
`endif
    end else begin
      peak_detected_o <= report_s;
      if (report_s) begin
        peak_idx_o <= max_idx_r;
        peak_val_o <= max_r;
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
        C0_o       <= c0_max_r;
        C1_o       <= c1_max_r;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pss_peak_detector.sv
// Testbench for pss_peak_detector.
// - Stimulus: directed patterns from the block description, then random traffic.
// - Reference: a model working on sample history and absolute sample positions.
// - Checking: expected reports go into a queue; a negedge monitor pops and
//   compares them against the DUT outputs.
module tb_pss_peak_detector;

  localparam int IN_DW           = 24;
  localparam int WINDOW_LEN      = 8;
  localparam int DETECTION_SHIFT = 2;
  localparam int PEAK_WIN        = 4;
  localparam int HOLDOFF_LEN     = 16;
  localparam int IDX_DW          = 16;

  logic                             clk_i = 1'b0;
  logic                             reset_ni;
  logic [IN_DW-1:0]                 s_axis_in_tdata;
  logic                             s_axis_in_tvalid;
  logic                             peak_detected_o;
  logic [IDX_DW-1:0]                peak_idx_o;
  logic [IN_DW-1:0]                 peak_val_o;
  logic [IN_DW+DETECTION_SHIFT-1:0] score_o;
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
  logic [63:0]                      C0_i, C1_i, C0_o, C1_o;
`endif

  pss_peak_detector dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .s_axis_in_tdata  (s_axis_in_tdata),
    .s_axis_in_tvalid (s_axis_in_tvalid),
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
    .C0_i             (C0_i),
    .C1_i             (C1_i),
    .C0_o             (C0_o),
    .C1_o             (C1_o),
`endif
    .peak_detected_o  (peak_detected_o),
    .peak_idx_o       (peak_idx_o),
    .peak_val_o       (peak_val_o),
    .score_o          (score_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp     = 0;
  int n_err     = 0;
  int pulse_cnt = 0;
  bit mon_en    = 1'b0;

  typedef struct {
    longint idx;
    longint val;
    longint c0;
    longint c1;
  } rep_t;

  rep_t   exp_q[$];
  longint hist[$];
  longint pos, max_val, max_pos, rearm_pos;
  longint max_c0, max_c1;
  bit     tracking;
  longint exp_score, exp_idx, exp_val, exp_c0, exp_c1;
  longint spikes[int];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Threshold from the last WINDOW_LEN accepted samples (zeros before the first).
  function automatic longint window_thr();
    longint s = 0;
    foreach (hist[i]) s += hist[i];
    return (s / WINDOW_LEN) * (64'sd1 << DETECTION_SHIFT);
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    pos       = 0;
    tracking  = 1'b0;
    rearm_pos = WINDOW_LEN;
    exp_score = 0;
    exp_idx   = 0;
    exp_val   = 0;
    exp_c0    = 0;
    exp_c1    = 0;
  endtask

  task automatic model_accept(input longint v, input longint c0, input longint c1);
    rep_t   r;
    longint thr = window_thr();
    if (tracking) begin
      if (v > max_val) begin
        max_val = v; max_pos = pos; max_c0 = c0; max_c1 = c1;
      end else if (pos - max_pos == PEAK_WIN) begin
        r.idx = max_pos % (64'sd1 << IDX_DW);
        r.val = max_val;
        r.c0  = max_c0;
        r.c1  = max_c1;
        exp_q.push_back(r);
        exp_idx = r.idx; exp_val = r.val; exp_c0 = r.c0; exp_c1 = r.c1;
        tracking  = 1'b0;
        rearm_pos = pos + HOLDOFF_LEN + 1;
      end
    end else if (pos >= rearm_pos && v > thr) begin
      tracking = 1'b1;
      max_val = v; max_pos = pos; max_c0 = c0; max_c1 = c1;
    end
    hist.push_back(v);
    if (hist.size() > WINDOW_LEN) void'(hist.pop_front());
    pos++;
    exp_score = window_thr();
  endtask

  // Monitor: every cycle, compare DUT outputs with what the model expects.
  always @(negedge clk_i) begin
    rep_t r;
    if (mon_en) begin
      if (peak_detected_o === 1'b1) pulse_cnt++;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("pulse", longint'(peak_detected_o), 1);
        check("rep_idx", longint'(peak_idx_o), r.idx);
        check("rep_val", longint'(peak_val_o), r.val);
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
        check("rep_c0", longint'(C0_o), r.c0);
        check("rep_c1", longint'(C1_o), r.c1);
`endif
      end else begin
        check("no_pulse", longint'(peak_detected_o), 0);
      end
      check("score", longint'(score_o), exp_score);
      check("held_idx", longint'(peak_idx_o), exp_idx);
      check("held_val", longint'(peak_val_o), exp_val);
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
      check("held_c0", longint'(C0_o), exp_c0);
      check("held_c1", longint'(C1_o), exp_c1);
`endif
    end
  end

  task automatic send(input longint v, input bit vld);
    longint c0 = {$urandom(), $urandom()};
    longint c1 = {$urandom(), $urandom()};
    s_axis_in_tdata  = IN_DW'(v);
    s_axis_in_tvalid = vld;
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
    C0_i = c0;
    C1_i = c1;
`endif
    @(posedge clk_i);
    if (vld) model_accept(v, c0, c1);
    #1;
  endtask

  task automatic apply_reset();
    reset_ni         = 1'b0;
    s_axis_in_tvalid = 1'b0;
    @(posedge clk_i);
    model_reset();
    #1;
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
  endtask

  // Background of 100 with spikes[] overrides; optional idle cycle between samples.
  task automatic run_pattern(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      send(spikes.exists(k) ? spikes[k] : 64'sd100, 1'b1);
      if (gaps) send(longint'($urandom_range(0, 5000)), 1'b0);
    end
    send(0, 1'b0);
    send(0, 1'b0);
  endtask

  task automatic scenario(input int n, input bit gaps, input int exp_pulses,
                          input longint exp_last_idx, input longint exp_last_val, input string name);
    int p0;
    apply_reset();
    p0 = pulse_cnt;
    run_pattern(n, gaps);
    check({name, "_pulses"}, pulse_cnt - p0, exp_pulses);
    if (exp_pulses > 0) begin
      check({name, "_idx"}, longint'(peak_idx_o), exp_last_idx);
      check({name, "_val"}, longint'(peak_val_o), exp_last_val);
    end
    spikes.delete();
  endtask

  initial begin
    int p0;
    reset_ni         = 1'b0;
    s_axis_in_tdata  = '0;
    s_axis_in_tvalid = 1'b0;
`ifdef PSS_PEAK_DETECTOR_CFO_CAPTURE_EN
    C0_i = '0;
    C1_i = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    mon_en = 1'b1;
    check("rst_pulse", longint'(peak_detected_o), 0);
    check("rst_idx", longint'(peak_idx_o), 0);
    check("rst_val", longint'(peak_val_o), 0);
    check("rst_score", longint'(score_o), 0);
    reset_ni = 1'b1;

    // Constant background: no detection, threshold settles at 400.
    p0 = pulse_cnt;
    run_pattern(64, 1'b0);
    check("const_pulses", pulse_cnt - p0, 0);
    check("const_score", longint'(score_o), 400);

    spikes[20] = 1000;
    scenario(50, 1'b0, 1, 20, 1000, "single");

    spikes[20] = 500; spikes[21] = 900; spikes[22] = 700;
    scenario(50, 1'b0, 1, 21, 900, "refine");

    spikes[20] = 1000; spikes[30] = 2000; spikes[60] = 1000;
    scenario(90, 1'b0, 2, 60, 1000, "holdoff");

    spikes[3] = 1000;
    scenario(40, 1'b0, 0, 0, 0, "warmup");

    spikes[20] = 1000;
    scenario(40, 1'b1, 1, 20, 1000, "gaps");

    spikes[20] = 1000; spikes[21] = 1000;
    scenario(40, 1'b0, 1, 20, 1000, "tie");

    spikes[20] = 400;
    scenario(40, 1'b0, 0, 0, 0, "thr_equal");

    spikes[20] = 401;
    scenario(40, 1'b0, 1, 20, 401, "thr_above");

    // Reset while tracking discards the pending peak.
    apply_reset();
    p0 = pulse_cnt;
    spikes[20] = 1000;
    for (int k = 0; k < 23; k++) send(spikes.exists(k) ? spikes[k] : 64'sd100, 1'b1);
    apply_reset();
    send(0, 1'b0);
    check("midreset_pulses", pulse_cnt - p0, 0);
    scenario(40, 1'b0, 1, 20, 1000, "post_reset");

    // Random traffic with random gaps and spikes.
    apply_reset();
    for (int k = 0; k < 1200; k++) begin
      longint v;
      if ($urandom_range(0, 24) == 0) v = longint'($urandom_range(300, 6000));
      else                            v = longint'($urandom_range(80, 120));
      send(v, ($urandom_range(0, 4) != 0));
    end
    send(0, 1'b0);
    send(0, 1'b0);
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
